// File: rtl/ibex_register_file_mp.sv
// Multi-ported register file with pending tracking and a clear sweep.
// R0 is hardwired; the highest-numbered write port wins collisions.
module ibex_register_file_mp #(
  parameter int unsigned          DataWidth   = 32,
  parameter int unsigned          NumRegs     = 32,
  parameter int unsigned          NumRead     = 2,
  parameter int unsigned          NumWrite    = 2,
  parameter bit                   WriteBypass = 1'b1,
  parameter logic [DataWidth-1:0] WordZeroVal = '0,
  parameter int unsigned          AddrWidth   = $clog2(NumRegs)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumRead*AddrWidth-1:0]  raddr_i,
  output logic [NumRead*DataWidth-1:0]  rdata_o,
  output logic [NumRead-1:0]            rpend_o,
  input  logic [NumWrite*AddrWidth-1:0] waddr_i,
  input  logic [NumWrite*DataWidth-1:0] wdata_i,
  input  logic [NumWrite-1:0]           we_i,
  input  logic                          alloc_i,
  input  logic [AddrWidth-1:0]          alloc_addr_i,
  input  logic                          clear_req_i,
  output logic                          busy_o,
  output logic                          clear_done_o,
  output logic                          wcoll_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DONE
  } state_e;

  state_e               state_q;
  logic [AddrWidth-1:0] ptr_q;
  logic                 busy_q;
  logic                 done_q;

  logic [DataWidth-1:0] mem_q [NumRegs-1:1];
  logic [NumRegs-1:1]   pend_q;

  logic [NumWrite-1:0]  we_eff;
  logic                 alloc_eff;
  logic                 sweep;
  logic [NumRegs-1:1]   wr_en;
  logic [NumRegs-1:1]   pend_set;
  logic [DataWidth-1:0] wr_dat [NumRegs-1:1];

  assign busy_o       = busy_q;
  assign clear_done_o = done_q;
  assign sweep        = (state_q == S_CLEAR);
  assign alloc_eff    = alloc_i & ~busy_q & (alloc_addr_i != '0);

  // Writes are dropped during the sweep and R0 writes never land.
  always_comb begin
    we_eff = '0;
    for (int w = 0; w < NumWrite; w++) begin
      we_eff[w] = we_i[w] & ~busy_q &
                  (waddr_i[w*AddrWidth +: AddrWidth] != '0);
    end
  end

  // Collision flag only exists with two write ports.
  if (NumWrite > 1) begin : g_coll
    assign wcoll_o = we_eff[0] & we_eff[1] &
      (waddr_i[0 +: AddrWidth] ==
       waddr_i[AddrWidth +: AddrWidth]);
  end else begin : g_nocoll
    assign wcoll_o = 1'b0;
  end

  // Per-register write select; later ports override, sweep wins.
  always_comb begin
    wr_en    = '0;
    pend_set = '0;
    for (int i = 1; i < NumRegs; i++) begin
      wr_dat[i] = WordZeroVal;
      for (int w = 0; w < NumWrite; w++) begin
        if (we_eff[w] &&
            waddr_i[w*AddrWidth +: AddrWidth] == AddrWidth'(i)) begin
          wr_en[i]  = 1'b1;
          wr_dat[i] = wdata_i[w*DataWidth +: DataWidth];
        end
      end
      if (sweep && ptr_q == AddrWidth'(i)) begin
        wr_en[i]  = 1'b1;
        wr_dat[i] = WordZeroVal;
      end
      pend_set[i] = alloc_eff && (alloc_addr_i == AddrWidth'(i));
    end
  end

  // Combinational reads with optional forwarding of this cycle's write.
  always_comb begin
    rdata_o = '0;
    rpend_o = '0;
    for (int p = 0; p < NumRead; p++) begin
      if (raddr_i[p*AddrWidth +: AddrWidth] == '0) begin
        rdata_o[p*DataWidth +: DataWidth] = WordZeroVal;
        rpend_o[p] = 1'b0;
      end else begin
        rdata_o[p*DataWidth +: DataWidth] =
          mem_q[raddr_i[p*AddrWidth +: AddrWidth]];
        rpend_o[p] = pend_q[raddr_i[p*AddrWidth +: AddrWidth]];
      end
      if (WriteBypass) begin
        for (int w = 0; w < NumWrite; w++) begin
          if (we_eff[w] &&
              waddr_i[w*AddrWidth +: AddrWidth] ==
              raddr_i[p*AddrWidth +: AddrWidth]) begin
            rdata_o[p*DataWidth +: DataWidth] =
              wdata_i[w*DataWidth +: DataWidth];
            rpend_o[p] = 1'b0;
          end
        end
      end
    end
  end

  // Register storage; alloc beats a same-cycle write on pending.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 1; i < NumRegs; i++) begin
        mem_q[i] <= WordZeroVal;
      end
      pend_q <= '0;
    end else begin
      for (int i = 1; i < NumRegs; i++) begin
        if (wr_en[i]) mem_q[i] <= wr_dat[i];
        if (pend_set[i]) pend_q[i] <= 1'b1;
        else if (wr_en[i]) pend_q[i] <= 1'b0;
      end
    end
  end

  // Clear sweep sequencer with registered busy/done flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (clear_req_i) begin
            state_q <= S_CLEAR;
            ptr_q   <= AddrWidth'(1);
            busy_q  <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (ptr_q == AddrWidth'(NumRegs - 1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            ptr_q <= ptr_q + AddrWidth'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
